// File: rtl/frame_scheduler.sv
// frame_scheduler: transmit-side frame controller. Snapshots the 40-bit frame
// word on a request and streams a preamble followed by 20 payload symbols
// (2 bits each, MSB first) to the QPSK mapper. An inter-frame gap follows each
// frame. One request can wait while a frame is in flight; any further request
// is dropped and counted.
//
// Handshake: sym_valid/sym_ready. A symbol transfers on a rising edge where
// both are high. While sym_valid is high and sym_ready is low, sym_o and all
// internal state hold. sym_valid is high throughout PREAMBLE and PAYLOAD and
// never drops mid-frame. Every output is a register, so nothing combinational
// runs from sym_ready to sym_o or sym_valid.
module frame_scheduler #(
  parameter int PREAMBLE_LEN = 8,
  parameter int GAP_CYCLES   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_req,
  input  logic [39:0] para_i,
  output logic [1:0]  sym_o,
  output logic        sym_valid,
  input  logic        sym_ready,
  output logic        busy,
  output logic        frame_done,
  output logic [7:0]  drop_cnt,
  output logic [1:0]  dbg_state,
  output logic        dbg_pending
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    PAYLOAD  = 2'd2,
    GAP      = 2'd3
  } state_t;

  localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_LEN - 1);
  localparam logic [7:0] PAY_LAST = 8'd19;
  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES);

  state_t      state, state_nxt;
  logic [39:0] sreg, sreg_nxt;
  logic [7:0]  sym_cnt, sym_cnt_nxt;
  logic [7:0]  gap_cnt, gap_cnt_nxt;
  logic        pending, pending_nxt;
  logic [7:0]  drop_nxt;
  logic [1:0]  sym_nxt;
  logic        valid_nxt;
  logic        done_nxt;
  logic        busy_nxt;
  logic        xfer;

  assign xfer        = sym_valid & sym_ready;
  assign dbg_state   = state;
  assign dbg_pending = pending;

  // Next-state, next-output and request-queue logic.
  always_comb begin
    state_nxt   = state;
    sreg_nxt    = sreg;
    sym_cnt_nxt = sym_cnt;
    gap_cnt_nxt = gap_cnt;
    pending_nxt = pending;
    drop_nxt    = drop_cnt;
    sym_nxt     = sym_o;
    valid_nxt   = sym_valid;
    done_nxt    = 1'b0;

    // Outside IDLE a request is queued once; later ones only bump the
    // saturating drop counter. In IDLE a request always starts a frame.
    if (state != IDLE && frame_req) begin
      if (!pending) begin
        pending_nxt = 1'b1;
      end else if (drop_cnt != 8'hFF) begin
        drop_nxt = drop_cnt + 8'd1;
      end
    end

    case (state)
      IDLE: begin
        if (frame_req || pending) begin
          sreg_nxt    = para_i;
          pending_nxt = 1'b0;
          sym_cnt_nxt = 8'd0;
          sym_nxt     = 2'b00;
          valid_nxt   = 1'b1;
          state_nxt   = PREAMBLE;
        end
      end
      PREAMBLE: begin
        if (xfer) begin
          if (sym_cnt == PRE_LAST) begin
            sym_cnt_nxt = 8'd0;
            sym_nxt     = sreg[39:38];
            state_nxt   = PAYLOAD;
          end else begin
            sym_cnt_nxt = sym_cnt + 8'd1;
            // Even index shows 00, odd index shows 11.
            sym_nxt     = sym_cnt[0] ? 2'b00 : 2'b11;
          end
        end
      end
      PAYLOAD: begin
        if (xfer) begin
          sreg_nxt = {sreg[37:0], 2'b00};
          if (sym_cnt == PAY_LAST) begin
            done_nxt    = 1'b1;
            valid_nxt   = 1'b0;
            sym_nxt     = 2'b00;
            gap_cnt_nxt = GAP_LOAD;
            state_nxt   = GAP;
          end else begin
            sym_cnt_nxt = sym_cnt + 8'd1;
            sym_nxt     = sreg[37:36];
          end
        end
      end
      GAP: begin
        // GAP occupies GAP_CYCLES+1 cycles, so busy falls GAP_CYCLES+1
        // cycles after frame_done.
        if (gap_cnt == 8'd0) begin
          state_nxt = IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt - 8'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
        sym_nxt   = 2'b00;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  // State, datapath and registered outputs, with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      sreg       <= 40'd0;
      sym_cnt    <= 8'd0;
      gap_cnt    <= 8'd0;
      pending    <= 1'b0;
      drop_cnt   <= 8'd0;
      sym_o      <= 2'b00;
      sym_valid  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      sreg       <= sreg_nxt;
      sym_cnt    <= sym_cnt_nxt;
      gap_cnt    <= gap_cnt_nxt;
      pending    <= pending_nxt;
      drop_cnt   <= drop_nxt;
      sym_o      <= sym_nxt;
      sym_valid  <= valid_nxt;
      busy       <= busy_nxt;
      frame_done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_frame_scheduler.sv
// tb_frame_scheduler: directed bench for frame_scheduler. Stimulus pushes the
// expected symbol stream into a queue; a monitor pops and compares on every
// transfer and checks that sym_o holds during stalls. A second instance with
// GAP_CYCLES=0 covers back-to-back frames.
module tb_frame_scheduler;

  localparam int PRE = 8;
  localparam int GAP = 16;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_n;
  logic        frame_req;
  logic        frame_req2;
  logic [39:0] para_i;

  logic [1:0] sym_o, sym_o2;
  logic       sym_valid, sym_valid2;
  logic       busy, busy2;
  logic       frame_done, frame_done2;
  logic [7:0] drop_cnt, drop_cnt2;
  logic [1:0] dbg_state, dbg_state2;
  logic       dbg_pending, dbg_pending2;

  // Ready generation: mode 0 = always ready, 1 = pattern 1,0,0,1, 2 = never.
  int         mode = 0;
  logic [1:0] rphase = 2'd0;
  logic       sym_ready;
  logic       sym_ready2;
  always @(posedge clk) rphase <= rphase + 2'd1;
  assign sym_ready  = (mode == 1) ? (rphase == 2'd0 || rphase == 2'd3) : (mode == 0);
  assign sym_ready2 = 1'b1;

  frame_scheduler #(.PREAMBLE_LEN(PRE), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .frame_req(frame_req), .para_i(para_i),
    .sym_o(sym_o), .sym_valid(sym_valid), .sym_ready(sym_ready),
    .busy(busy), .frame_done(frame_done), .drop_cnt(drop_cnt),
    .dbg_state(dbg_state), .dbg_pending(dbg_pending)
  );

  frame_scheduler #(.PREAMBLE_LEN(PRE), .GAP_CYCLES(0)) dut_gap0 (
    .clk(clk), .rst_n(rst_n), .frame_req(frame_req2), .para_i(para_i),
    .sym_o(sym_o2), .sym_valid(sym_valid2), .sym_ready(sym_ready2),
    .busy(busy2), .frame_done(frame_done2), .drop_cnt(drop_cnt2),
    .dbg_state(dbg_state2), .dbg_pending(dbg_pending2)
  );

  // Hand-decoded payloads: 40'hCC1718195A and 40'hCC1718195B, MSB first.
  logic [1:0] pay_5a [20] = '{2'd3, 2'd0, 2'd3, 2'd0, 2'd0, 2'd1, 2'd1, 2'd3, 2'd0, 2'd1,
                              2'd2, 2'd0, 2'd0, 2'd1, 2'd2, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2};
  logic [1:0] pay_5b [20] = '{2'd3, 2'd0, 2'd3, 2'd0, 2'd0, 2'd1, 2'd1, 2'd3, 2'd0, 2'd1,
                              2'd2, 2'd0, 2'd0, 2'd1, 2'd2, 2'd1, 2'd1, 2'd1, 2'd2, 2'd3};

  // Scoreboard
  logic [1:0] exp_q[$];
  logic [1:0] exp2_q[$];
  int checks = 0;
  int errors = 0;
  int xfer = 0, done_n = 0, xfer2 = 0, done2_n = 0;
  int rise_q[$], done_q[$], rise2_q[$], done2_q[$];
  logic       prev_stall = 1'b0, prev_valid = 1'b0, prev_valid2 = 1'b0;
  logic [1:0] prev_sym = 2'b00;
  logic [1:0] exp_sym;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor for the main instance: compare every transfer, hold during stalls.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (sym_valid && !prev_valid) rise_q.push_back(cyc);
      if (frame_done) begin
        done_n++;
        done_q.push_back(cyc);
      end
      if (prev_stall) check("stall_hold", sym_o, prev_sym);
      if (sym_valid && sym_ready) begin
        xfer++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_sym: got %0d, expected no transfer (cycle %0d)", sym_o, cyc);
        end else begin
          exp_sym = exp_q.pop_front();
          check("sym", sym_o, exp_sym);
        end
      end
      prev_stall = sym_valid && !sym_ready;
      prev_sym   = sym_o;
      prev_valid = sym_valid;
    end
  end

  // Monitor for the GAP_CYCLES=0 instance.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid2 = 1'b0;
    end else begin
      if (sym_valid2 && !prev_valid2) rise2_q.push_back(cyc);
      if (frame_done2) begin
        done2_n++;
        done2_q.push_back(cyc);
      end
      if (sym_valid2 && sym_ready2) begin
        xfer2++;
        if (exp2_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_sym2: got %0d, expected no transfer (cycle %0d)", sym_o2, cyc);
        end else begin
          check("sym2", sym_o2, exp2_q.pop_front());
        end
      end
      prev_valid2 = sym_valid2;
    end
  end

  // Driver tasks
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_req(input bit second);
    if (second) frame_req2 = 1'b1; else frame_req = 1'b1;
    tick();
    frame_req2 = 1'b0;
    frame_req  = 1'b0;
  endtask

  task automatic push_frame(input bit use_b, input int n, input bit to2);
    logic [1:0] s;
    for (int k = 0; k < n; k++) begin
      if (k < PRE) s = (k % 2 == 1) ? 2'b11 : 2'b00;
      else if (use_b) s = pay_5b[k-PRE];
      else s = pay_5a[k-PRE];
      if (to2) exp2_q.push_back(s); else exp_q.push_back(s);
    end
  endtask

  // Wait until `target` frames are done and the instance is idle again.
  task automatic wait_frames(input bit second, input int target, input int bound, input string name);
    int n;
    n = 0;
    if (second) begin
      while ((done2_n < target || busy2) && n < bound) begin tick(); n++; end
    end else begin
      while ((done_n < target || busy) && n < bound) begin tick(); n++; end
    end
    checks++;
    if (n >= bound) begin
      errors++;
      $display("FAIL %s: timeout after %0d cycles, expected idle", name, n);
    end
  endtask

  int bx, bd;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    // Reset values, with frame_req held high during reset
    rst_n = 1'b0; frame_req = 1'b1; frame_req2 = 1'b0; para_i = 40'd0;
    tick(3);
    check("rst_sym_o", sym_o, 0);
    check("rst_sym_valid", sym_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_pending", dbg_pending, 0);
    check("rst_state", dbg_state, 0);
    frame_req = 1'b0; rst_n = 1'b1;
    tick(2);

    // Single frame, defaults
    para_i = 40'hCC1718195A;
    push_frame(0, PRE + 20, 0);
    bx = xfer; bd = done_n; rise_q.delete(); done_q.delete();
    pulse_req(0);
    wait_frames(0, bd + 1, 200, "single_wait");
    check("single_xfers", xfer - bx, 28);
    check("single_done", done_n - bd, 1);
    check("single_q_empty", exp_q.size(), 0);
    check("single_done_lat", done_q[0] - rise_q[0], 28);
    check("single_busy_fall", cyc - done_q[0], GAP + 1);

    // Backpressure with ready pattern 1,0,0,1
    mode = 1;
    push_frame(0, PRE + 20, 0);
    bx = xfer; bd = done_n;
    pulse_req(0);
    wait_frames(0, bd + 1, 400, "bp_wait");
    mode = 0;
    check("bp_xfers", xfer - bx, 28);
    check("bp_done", done_n - bd, 1);
    check("bp_q_empty", exp_q.size(), 0);

    // Queueing and drops: 3 extra requests, para_i changed mid-frame
    para_i = 40'hCC1718195A;
    push_frame(0, PRE + 20, 0);
    push_frame(1, PRE + 20, 0);
    bx = xfer; bd = done_n; rise_q.delete(); done_q.delete();
    pulse_req(0);
    tick(2); pulse_req(0);
    tick(1); pulse_req(0);
    tick(1); pulse_req(0);
    para_i = 40'hCC1718195B;
    tick(2);
    check("q_pending", dbg_pending, 1);
    check("q_drop_cnt", drop_cnt, 2);
    wait_frames(0, bd + 2, 300, "q_wait");
    tick(60);
    check("q_xfers", xfer - bx, 56);
    check("q_done", done_n - bd, 2);
    check("q_q_empty", exp_q.size(), 0);
    check("q_restart_lat", rise_q[1] - done_q[0], GAP + 2);
    check("q_state_idle", dbg_state, 0);
    check("q_pending_clr", dbg_pending, 0);

    // Request in the IDLE cycle while a request is pending
    para_i = 40'hCC1718195A;
    push_frame(0, PRE + 20, 0);
    push_frame(0, PRE + 20, 0);
    bx = xfer; bd = done_n; rise_q.delete(); done_q.delete();
    pulse_req(0);
    tick(4); pulse_req(0);
    wait_frames(0, bd + 1, 200, "sim_wait1");
    check("sim_idle_pending", dbg_pending, 1);
    pulse_req(0);
    check("sim_pending_clr", dbg_pending, 0);
    check("sim_drop_cnt", drop_cnt, 2);
    wait_frames(0, bd + 2, 200, "sim_wait2");
    tick(60);
    check("sim_xfers", xfer - bx, 56);
    check("sim_done", done_n - bd, 2);
    check("sim_q_empty", exp_q.size(), 0);
    check("sim_restart_lat", rise_q[1] - done_q[0], GAP + 2);

    // GAP_CYCLES=0: back-to-back frames
    para_i = 40'hCC1718195A;
    push_frame(0, PRE + 20, 1);
    push_frame(0, PRE + 20, 1);
    pulse_req(1);
    tick(4); pulse_req(1);
    wait_frames(1, 2, 300, "gap0_wait");
    tick(10);
    check("gap0_xfers", xfer2, 56);
    check("gap0_done", done2_n, 2);
    check("gap0_q_empty", exp2_q.size(), 0);
    check("gap0_restart_lat", rise2_q[1] - done2_q[0], 2);
    check("gap0_drop_cnt", drop_cnt2, 0);
    check("gap0_state_idle", dbg_state2, 0);
    check("gap0_pending", dbg_pending2, 0);

    // Mid-frame reset during payload symbol index 10
    para_i = 40'hCC1718195A;
    push_frame(0, PRE + 10, 0);
    bx = xfer; bd = done_n;
    pulse_req(0);
    tick(PRE + 10);
    rst_n = 1'b0; mode = 2;
    tick();
    check("mrst_sym_valid", sym_valid, 0);
    check("mrst_busy", busy, 0);
    check("mrst_frame_done", frame_done, 0);
    rst_n = 1'b1; mode = 0;
    tick(2);
    check("mrst_xfers", xfer - bx, PRE + 10);
    check("mrst_no_done", done_n - bd, 0);
    check("mrst_q_empty", exp_q.size(), 0);
    check("mrst_drop_clr", drop_cnt, 0);
    push_frame(0, PRE + 20, 0);
    bx = xfer; bd = done_n;
    pulse_req(0);
    wait_frames(0, bd + 1, 200, "mrst_wait");
    check("mrst_full_xfers", xfer - bx, 28);
    check("mrst_full_done", done_n - bd, 1);
    check("mrst_full_q_empty", exp_q.size(), 0);

    // Drop counter saturation: frame stalled, 301 requests (1 queued, 300 dropped)
    mode = 2;
    pulse_req(0);
    frame_req = 1'b1;
    tick(301);
    frame_req = 1'b0;
    check("sat_drop_cnt", drop_cnt, 255);
    check("sat_pending", dbg_pending, 1);
    check("sat_sym_valid", sym_valid, 1);
    tick(5);
    check("sat_hold", drop_cnt, 255);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; mode = 0;
    tick(2);
    check("sat_rst_drop", drop_cnt, 0);
    check("final_q_empty", exp_q.size(), 0);
    check("final_q2_empty", exp2_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
